shift_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of the 16-bit shift register and drives its load and shift-enable inputs. On a start request it issues one load pulse, then exactly N shift-enable pulses (N captured at start, 0..16), honouring a stall input, and signals completion with a one-cycle done pulse. It lets a datapath such as a shift-and-add multiplier or serial transmitter shift a word by a programmed amount without cycle-counting logic of its own.

---
 rtl/shift_ctrl.sv | 100 ++++++++++
 tb/tb_shift_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_ctrl.sv
// shift_ctrl: sequences one load strobe followed by N shift-enable strobes
// (N = 0..WIDTH, captured at start) for a downstream shift register.
// Shift enables can be stalled with pause, and abort cancels the operation.
// Completion is flagged with a one-cycle done pulse.
module shift_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,      // asynchronous, active low
  input  logic             start,
  input  logic [CNT_W-1:0] shAmt,
  input  logic             pause,
  input  logic             abort,
  output logic             ld,
  output logic             shEn,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] shCount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_WIDTH = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_amt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_amt_sat;
  logic             w_last;

  // Requests beyond the register width saturate to a full-width shift.
  assign w_amt_sat = (shAmt > C_WIDTH) ? C_WIDTH : shAmt;
  // The strobe issued while the count equals amt-1 is the final one.
  assign w_last    = (r_count == (r_amt - C_ONE));
  assign shCount   = r_count;

  // Next-state and strobe decode; shEn is the only output that is not
  // purely a function of state.
  always_comb begin
    w_state_next = r_state;
    ld           = 1'b0;
    shEn         = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        ld = 1'b1;
        if (abort)              w_state_next = S_IDLE;
        else if (r_amt == '0)   w_state_next = S_DONE;
        else                    w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        shEn = ~pause & ~abort;
        if (abort)               w_state_next = S_IDLE;
        else if (!pause && w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Capture the saturated shift amount when a start is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_amt <= '0;
    else if (r_state == S_IDLE && start) r_amt <= w_amt_sat;
  end

  // Count issued shift enables; cleared by LOAD and held otherwise so the
  // last operation's count stays visible until the next one starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_count <= '0;
    else if (r_state == S_LOAD) r_count <= '0;
    else if (shEn)             r_count <= r_count + C_ONE;
  end

endmodule

// File: tb/tb_shift_ctrl.sv
// Testbench for shift_ctrl: cycle-by-cycle vector table plus hand-written
// sequences for reset, downstream register effect and saturation.
module tb_shift_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] shAmt;
  logic       pause;
  logic       abort;
  logic       ld;
  logic       shEn;
  logic       busy;
  logic       done;
  logic [4:0] shCount;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       start;
    logic [4:0] amt;
    logic       pause;
    logic       abort;
    logic [8:0] exp;   // {ld, shEn, busy, done, shCount}
  } vec_t;

  vec_t vecs[$];

  shift_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .shAmt   (shAmt),
    .pause   (pause),
    .abort   (abort),
    .ld      (ld),
    .shEn    (shEn),
    .busy    (busy),
    .done    (done),
    .shCount (shCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic add(input logic s, input int a, input logic p, input logic ab,
                     input logic e_ld, input logic e_se, input logic e_b,
                     input logic e_d, input int e_c);
    vec_t v;
    v.start = s;
    v.amt   = 5'(a);
    v.pause = p;
    v.abort = ab;
    v.exp   = {e_ld, e_se, e_b, e_d, 5'(e_c)};
    vecs.push_back(v);
  endtask

  // One operation observed from the outside, with a behavioural 16-bit
  // shift-left register driven by the strobes.
  task automatic run_op(input int amt, input logic [15:0] din, input int exp_n,
                        input logic [15:0] exp_sr, input string name);
    int          n_sh;
    int          n_ld;
    int          cyc;
    bit          seen;
    logic [15:0] sr;
    start = 1'b1;
    shAmt = 5'(amt);
    @(posedge clk); #1;
    start = 1'b0;
    shAmt = 5'd0;
    n_sh = 0; n_ld = 0; cyc = 0; seen = 0; sr = 16'h0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ld) begin
        n_ld++;
        sr = din;
      end else if (shEn) begin
        n_sh++;
        sr = {sr[14:0], 1'b0};
      end
      if (done) seen = 1;
      if (!seen) begin
        @(posedge clk); #1;
      end
    end
    check({name, "_latency"}, cyc, exp_n + 2);
    check({name, "_ld_pulses"}, n_ld, 1);
    check({name, "_shen_pulses"}, n_sh, exp_n);
    check({name, "_register"}, sr, exp_sr);
    check({name, "_shcount"}, shCount, exp_n);
    @(posedge clk); #1;
    $display("op %s amt=%0d: cycles=%0d shifts=%0d reg=0x%04h", name, amt, cyc, n_sh, sr);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    shAmt = 5'd0;
    pause = 1'b0;
    abort = 1'b0;

    // ---- vector table: (start, amt, pause, abort | ld, shEn, busy, done, cnt)
    // amt = 0: load then done, no shifts
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // amt = 3 with two pause cycles after the first shift
    add(1, 3, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 1, 1, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 3);
    // amt = 20 saturates to 16
    add(1, 20, 0, 0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 1, 0, 3);
    for (int i = 0; i < 16; i++) add(0, 0, 0, 0, 0, 1, 1, 0, i);
    add(0, 0, 0, 0, 0, 0, 1, 1, 16);
    add(0, 0, 0, 0, 0, 0, 0, 0, 16);
    // amt = 10, abort after the 4th shift
    add(1, 10, 0, 0, 0, 0, 0, 0, 16);
    add(0, 0, 0, 0, 1, 0, 1, 0, 16);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 1, 1, 0, i);
    add(0, 0, 0, 1, 0, 0, 1, 0, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, 4);
    add(0, 0, 0, 1, 0, 0, 0, 0, 4);
    // start held high through an amt = 5 run: next run only after DONE
    add(1, 5, 0, 0, 0, 0, 0, 0, 4);
    add(1, 5, 0, 0, 1, 0, 1, 0, 4);
    for (int i = 0; i < 5; i++) add(1, 5, 0, 0, 0, 1, 1, 0, i);
    add(1, 5, 0, 0, 0, 0, 1, 1, 5);
    add(1, 5, 0, 0, 0, 0, 0, 0, 5);
    add(0, 0, 0, 0, 1, 0, 1, 0, 5);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 1, 1, 0, i);
    add(0, 0, 0, 0, 0, 0, 1, 1, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0, 5);
    // abort during LOAD: back to IDLE, count still cleared
    add(1, 2, 0, 0, 0, 0, 0, 0, 5);
    add(0, 0, 0, 1, 1, 0, 1, 0, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // amt = 1 with an initial pause; start/abort ignored in DONE
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(1, 7, 0, 1, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // ---- reset state, checked before any clock edge
    #2;
    check("reset_outputs", {ld, shEn, busy, done, shCount}, 9'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // ---- apply table
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start;
      shAmt = vecs[i].amt;
      pause = vecs[i].pause;
      abort = vecs[i].abort;
      @(negedge clk);
      checks++;
      if ({ld, shEn, busy, done, shCount} !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec[%0d] {ld,shEn,busy,done,cnt}: got %b expected %b",
                 i, {ld, shEn, busy, done, shCount}, vecs[i].exp);
      end else begin
        $display("vec[%0d] start=%b amt=%0d pause=%b abort=%b -> %b", i,
                 vecs[i].start, vecs[i].amt, vecs[i].pause, vecs[i].abort,
                 {ld, shEn, busy, done, shCount});
      end
      @(posedge clk); #1;
    end
    start = 1'b0; shAmt = 5'd0; pause = 1'b0; abort = 1'b0;

    // ---- downstream register effect
    run_op(16, 16'h8001, 16, 16'h0000, "full16");
    run_op(15, 16'h0001, 15, 16'h8000, "shift15");
    run_op(20, 16'hFFFF, 16, 16'h0000, "sat20");

    // ---- asynchronous reset in the middle of a 16-shift operation
    start = 1'b1; shAmt = 5'd16;
    @(posedge clk); #1;
    start = 1'b0; shAmt = 5'd0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_shen", {shEn, busy}, 2'b11);
    rst = 1'b0;
    #1;
    check("midop_reset_outputs", {ld, shEn, busy, done, shCount}, 9'd0);
    $display("reset asserted mid-shift: outputs %b", {ld, shEn, busy, done, shCount});
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_idle", {ld, shEn, busy, done, shCount}, 9'd0);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
